// File: rtl/trace_event_packer.sv
// trace_event_packer: compacts valid trace channels into a header + payload beat stream.
// Optional timestamp field in the header enabled by defining TRACE_PACKER_TS_EN.
module trace_event_packer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 64,
    parameter int OUT_W  = 32,
    parameter int TS_W   = 12
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_areset,
    input  logic [NUM_CH*CH_W-1:0]             in_data,
    input  logic [NUM_CH-1:0]                  in_mask,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [$clog2(NUM_CH*CH_W+1)-1:0]   pkt_bits,
    output logic [OUT_W-1:0]                   out_data,
    output logic                               out_valid,
    output logic                               out_last,
    input  logic                               out_ready
);
    localparam int BPC  = CH_W / OUT_W;
    localparam int PW   = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int BW   = BPC > 1 ? $clog2(BPC) : 1;
    localparam int CW   = $clog2(NUM_CH + 1);
    localparam int PB_W = $clog2(NUM_CH*CH_W + 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t                   state_q, state_d;
    logic [NUM_CH*CH_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic [OUT_W-1:0]         hdr_q, hdr_d;
    logic [PB_W-1:0]          pkt_bits_q, pkt_bits_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [CW-1:0]            cnt;
    logic                     is_last;
`ifdef TRACE_PACKER_TS_EN
    logic [TS_W-1:0]          ts_q;
`endif

    // lowest set channel at or above index from
    function automatic logic [PW-1:0] lowest_from(input logic [NUM_CH-1:0] m, input int from);
        lowest_from = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (k >= from && m[k]) lowest_from = PW'(k);
    endfunction

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            hdr_q      <= '0;
            pkt_bits_q <= '0;
            ptr_q      <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            hdr_q      <= hdr_d;
            pkt_bits_q <= pkt_bits_d;
            ptr_q      <= ptr_d;
            beat_q     <= beat_d;
        end
    end

`ifdef TRACE_PACKER_TS_EN
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) ts_q <= '0;
        else ts_q <= ts_q + 1'b1;
    end
`endif

    always_comb begin
        cnt = '0;
        for (int k = 0; k < NUM_CH; k++) cnt = cnt + CW'(in_mask[k]);
    end

    assign is_last = beat_q == BW'(BPC - 1) && (mask_q >> ptr_q) == NUM_CH'(1);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mask_d     = mask_q;
        hdr_d      = hdr_q;
        pkt_bits_d = pkt_bits_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        case (state_q)
            IDLE: if (in_valid && |in_mask) begin
                state_d    = HDR;
                data_d     = in_data;
                mask_d     = in_mask;
                pkt_bits_d = PB_W'(cnt * CH_W);
                hdr_d      = '0;
                hdr_d[NUM_CH-1:0]  = in_mask;
                hdr_d[NUM_CH+:16]  = 16'(cnt * BPC);
`ifdef TRACE_PACKER_TS_EN
                hdr_d[NUM_CH+16+:TS_W] = ts_q;
`endif
            end
            HDR: if (out_ready) begin
                state_d = PAY;
                ptr_d   = lowest_from(mask_q, 0);
                beat_d  = '0;
            end
            PAY: if (out_ready) begin
                if (is_last) state_d = IDLE;
                else if (beat_q == BW'(BPC - 1)) begin
                    beat_d = '0;
                    ptr_d  = lowest_from(mask_q, int'(ptr_q) + 1);
                end else beat_d = beat_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q != IDLE;
        out_last  = state_q == PAY && is_last;
        pkt_bits  = pkt_bits_q;
        out_data  = state_q == HDR ? hdr_q :
                    state_q == PAY ? data_q[int'(ptr_q)*CH_W + int'(beat_q)*OUT_W +: OUT_W] : '0;
    end
endmodule

// File: tb/tb_trace_event_packer.sv
// tb_trace_event_packer: randomized packet checks against a queue-based reference model.
module tb_trace_event_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] in_data;
    logic [3:0]   in_mask;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   pkt_bits;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [8:0]   last_bits = '0;

    trace_event_packer #(.NUM_CH(4), .CH_W(64), .OUT_W(32), .TS_W(12)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst), .in_data(in_data), .in_mask(in_mask),
        .in_valid(in_valid), .in_ready(in_ready), .pkt_bits(pkt_bits), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1; abort_at: beat index to reset on
    task automatic do_packet(input logic [3:0] m, input logic [255:0] d, input int mode, input int abort_at);
        logic [31:0] exp_q[$];
        logic [31:0] hdr;
        int cnt, n, idx, budget, pc;
        cnt = $countones(m);
        hdr = 32'(m) | (32'(cnt * 2) << 4);
`ifdef TRACE_PACKER_TS_EN
        hdr = hdr | (32'(cyc % 4096) << 20);
`endif
        exp_q.push_back(hdr);
        for (int k = 0; k < 4; k++)
            if (m[k]) for (int b = 0; b < 2; b++) exp_q.push_back(d[k*64 + b*32 +: 32]);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b want=1", in_ready); end
        in_data = d; in_mask = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {8{$urandom}}; in_mask = 4'($urandom);
        if (m == 4'b0) begin
            checks += 3;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got=%b want=1", in_ready); end
            if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got=%b want=0", out_valid); end
            if (pkt_bits !== last_bits) begin errors++; $display("FAIL empty_bits got=%0d want=%0d", pkt_bits, last_bits); end
            return;
        end
        last_bits = 9'(cnt * 64);
        checks++;
        if (pkt_bits !== last_bits) begin errors++; $display("FAIL pkt_bits got=%0d want=%0d", pkt_bits, last_bits); end
        n = exp_q.size(); idx = 0; budget = 0; pc = 0;
        while (idx < n && budget < 200) begin
            if (abort_at == idx) begin
                out_ready = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                checks += 4;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", out_valid); end
                if (out_last !== 1'b0) begin errors++; $display("FAIL abort_last got=%b want=0", out_last); end
                if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", in_ready); end
                if (pkt_bits !== 9'd0) begin errors++; $display("FAIL abort_bits got=%0d want=0", pkt_bits); end
                rst = 1'b0; last_bits = '0;
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_tail got=%b want=0", out_valid); end
                return;
            end
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL beat%0d_valid got=%b want=1", idx, out_valid); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL beat%0d_inready got=%b want=0", idx, in_ready); end
            if (out_data !== exp_q[idx]) begin errors++; $display("FAIL beat%0d_data got=%h want=%h", idx, out_data, exp_q[idx]); end
            if (out_last !== (idx == n - 1)) begin errors++; $display("FAIL beat%0d_last got=%b want=%b", idx, out_last, idx == n - 1); end
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : (pc % 4 == 0 || pc % 4 == 3);
            pc++;
            @(posedge clk); #1;
            if (out_ready) idx++;
            budget++;
        end
        out_ready = 1'b0;
        checks += 3;
        if (idx !== n) begin errors++; $display("FAIL transfers got=%0d want=%0d", idx, n); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b want=0", out_last); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h want=0", out_data); end
        if (pkt_bits !== 9'd0) begin errors++; $display("FAIL rst_bits got=%0d want=0", pkt_bits); end
        rst = 1'b0; last_bits = '0;
    endtask

    task automatic test_example;
        do_packet(4'b0101, {128'h0, 64'hAAAABBBB_CCCCDDDD, 64'h11112222_33334444}, 0, -1);
    endtask

    task automatic test_empty;
        do_packet(4'b0000, {8{$urandom}}, 0, -1);
    endtask

    task automatic test_full;
        do_packet(4'b1111, {8{$urandom}}, 0, -1);
    endtask

    task automatic test_stall;
        do_packet(4'b1000, {8{$urandom}}, 2, -1);
    endtask

    task automatic test_reset_mid;
        do_packet(4'b0101, {8{$urandom}}, 0, 2);
        do_packet(4'b0110, {8{$urandom}}, 0, -1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 25; i++) do_packet(4'($urandom), {8{$urandom}}, 1, -1);
    endtask

    task automatic test_ts;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_packet(4'b0011, {8{$urandom}}, 0, -1);
        repeat (4100) @(posedge clk);
        #1;
        do_packet(4'b1001, {8{$urandom}}, 1, -1);
    endtask

    initial begin
        test_reset;
        test_example;
        test_empty;
        test_full;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        test_ts;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
